// File: rtl/npu_pkg.sv
// Shared NPU definitions: default datapath widths and the
// writeback controller state encoding.
package npu_pkg;

    localparam int BIT_DEPTH_D  = 8;
    localparam int ADDR_WIDTH_D = 10;
    localparam int ACC_WIDTH_D  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } wb_state_e;

endpackage

// File: rtl/res_quant.sv
// Combinational requantiser: round-half-up arithmetic shift,
// optional ReLU, then signed saturation to BIT_DEPTH bits.
module res_quant
    import npu_pkg::*;
#(
    parameter int BIT_DEPTH = BIT_DEPTH_D,
    parameter int ACC_WIDTH = ACC_WIDTH_D
) (
    input  logic [ACC_WIDTH-1:0] acc_i,
    input  logic [4:0]           shift_i,
    input  logic                 relu_i,
    output logic [BIT_DEPTH-1:0] data_o
);

    localparam logic signed [ACC_WIDTH:0] MAXV =
        {{(ACC_WIDTH-BIT_DEPTH+2){1'b0}}, {(BIT_DEPTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] MINV =
        {{(ACC_WIDTH-BIT_DEPTH+2){1'b1}}, {(BIT_DEPTH-1){1'b0}}};

    logic signed [ACC_WIDTH:0] ext;
    logic signed [ACC_WIDTH:0] rnd;
    logic signed [ACC_WIDTH:0] sum;
    logic signed [ACC_WIDTH:0] shr;
    logic signed [ACC_WIDTH:0] clip;

    // One guard bit keeps acc + half-LSB from wrapping.
    assign ext = $signed({acc_i[ACC_WIDTH-1], acc_i});

    always_comb begin
        rnd = '0;
        if (shift_i != 5'd0) begin
            rnd = {{ACC_WIDTH{1'b0}}, 1'b1} << (shift_i - 5'd1);
        end
    end

    assign sum = ext + rnd;
    assign shr = sum >>> shift_i;

    always_comb begin
        clip = shr;
        if (relu_i && shr[ACC_WIDTH]) begin
            clip = '0;
        end
        if (clip > MAXV) begin
            clip = MAXV;
        end else if (clip < MINV) begin
            clip = MINV;
        end
    end

    assign data_o = clip[BIT_DEPTH-1:0];

endmodule

// File: rtl/res_writeback.sv
// Result writeback: accepts accumulator beats for one job,
// requantises them and writes them to consecutive buffer addresses.
module res_writeback
    import npu_pkg::*;
#(
    parameter int BIT_DEPTH  = BIT_DEPTH_D,
    parameter int ADDR_WIDTH = ADDR_WIDTH_D,
    parameter int ACC_WIDTH  = ACC_WIDTH_D
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [4:0]            shift,
    input  logic                  relu_en,
    input  logic [ACC_WIDTH-1:0]  acc_in,
    input  logic                  acc_valid,
    output logic                  acc_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [BIT_DEPTH-1:0]  wr_data,
    output logic                  busy,
    output logic                  done
);

    wb_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   cnt_q;
    logic [4:0]            shift_q;
    logic                  relu_q;

    logic                  s1_v_q;
    logic [ACC_WIDTH-1:0]  s1_acc_q;
    logic [ADDR_WIDTH-1:0] s1_addr_q;
    logic                  s2_v_q;
    logic [BIT_DEPTH-1:0]  s2_data_q;
    logic [ADDR_WIDTH-1:0] s2_addr_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [BIT_DEPTH-1:0]  wr_data_q;

    logic                  start_ok;
    logic                  accept;
    logic                  last_beat;
    logic [BIT_DEPTH-1:0]  quant;

    assign start_ok  = start && (state_q == ST_IDLE);
    assign accept    = acc_valid && acc_ready;
    assign last_beat = accept && ((cnt_q + 1'b1) == len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (length == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_beat) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!s1_v_q && !s2_v_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        acc_ready = (state_q == ST_RUN) && (cnt_q < len_q);
        busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        done      = (state_q == ST_DONE);
    end

    // Job parameters are frozen on the accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
        end else if (start_ok) begin
            base_q  <= base_addr;
            len_q   <= length;
            cnt_q   <= '0;
            shift_q <= shift;
            relu_q  <= relu_en;
        end else if (accept) begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    res_quant #(
        .BIT_DEPTH (BIT_DEPTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_quant (
        .acc_i   (s1_acc_q),
        .shift_i (shift_q),
        .relu_i  (relu_q),
        .data_o  (quant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_acc_q  <= '0;
            s1_addr_q <= '0;
            s2_v_q    <= 1'b0;
            s2_data_q <= '0;
            s2_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            s1_v_q  <= accept;
            s2_v_q  <= s1_v_q;
            wr_en_q <= s2_v_q;
            if (accept) begin
                s1_acc_q  <= acc_in;
                s1_addr_q <= base_q + cnt_q[ADDR_WIDTH-1:0];
            end
            if (s1_v_q) begin
                s2_data_q <= quant;
                s2_addr_q <= s1_addr_q;
            end
            // Address/data hold their last value between writes.
            if (s2_v_q) begin
                wr_addr_q <= s2_addr_q;
                wr_data_q <= s2_data_q;
            end
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_res_writeback.sv
// Scoreboard bench for res_writeback with a behavioural
// requantisation model and randomised jobs.
module tb_res_writeback;

    localparam int BD  = 8;
    localparam int AW  = 10;
    localparam int ACW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic [4:0]    shift = '0;
    logic          relu_en = 1'b0;
    logic [ACW-1:0] acc_in = '0;
    logic          acc_valid = 1'b0;
    logic          acc_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [BD-1:0] wr_data;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    res_writeback #(
        .BIT_DEPTH  (BD),
        .ADDR_WIDTH (AW),
        .ACC_WIDTH  (ACW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .shift     (shift),
        .relu_en   (relu_en),
        .acc_in    (acc_in),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_done[$];
    int  dv[$];
    wr_t pe;
    wr_t me;
    int  md;

    int cyc = 0;
    int nvec = 0;
    int nerr = 0;
    int m_k = 0;
    int m_len = 0;
    int m_base = 0;
    int m_shift = 0;
    bit m_relu = 1'b0;
    bit m_active = 1'b0;
    int m_next_idle = 0;
    int last_addr = 0;
    int last_data = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Round-half-up divide by 2^sh with floor semantics, ReLU, clamp.
    function automatic int model(input int acc, input int sh,
                                 input bit relu);
        longint v;
        longint d;
        longint q;
        longint hi;
        longint lo;
        v  = acc;
        d  = longint'(1) << sh;
        hi = (longint'(1) << (BD - 1)) - 1;
        lo = -(longint'(1) << (BD - 1));
        if (sh > 0) v = v + d / 2;
        q = v / d;
        if (q * d != v && v < 0) q = q - 1;
        if (relu && q < 0) q = 0;
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return int'(q);
    endfunction

    // Stimulus tracker: records accepted starts/beats as expectations.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_active    = 1'b0;
            m_k         = 0;
            m_next_idle = 0;
        end else if (start && !m_active && cyc >= m_next_idle) begin
            m_base  = int'(base_addr);
            m_len   = int'(length);
            m_shift = int'(shift);
            m_relu  = relu_en;
            m_k     = 0;
            m_active = (length != '0);
            if (length == '0) begin
                exp_done.push_back(cyc + 1);
                m_next_idle = cyc + 2;
            end
        end else begin
            chk("acc_ready", acc_ready, m_active);
            if (m_active && acc_valid) begin
                pe.cyc  = cyc + 3;
                pe.addr = (m_base + m_k) % (1 << AW);
                pe.data = model($signed(acc_in), m_shift, m_relu);
                exp_wr.push_back(pe);
                m_k++;
                if (m_k == m_len) begin
                    m_active = 1'b0;
                    exp_done.push_back(cyc + 4);
                    m_next_idle = cyc + 5;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT writes or signals done.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                if (exp_wr.size() == 0) begin
                    chk("wr_en_unexpected", wr_en, 0);
                end else begin
                    me = exp_wr.pop_front();
                    chk("wr_cycle", cyc, me.cyc);
                    chk("wr_addr", wr_addr, me.addr);
                    chk("wr_data", $signed(wr_data), me.data);
                    last_addr = me.addr;
                    last_data = me.data;
                end
            end else begin
                chk("wr_addr_hold", wr_addr, last_addr);
                chk("wr_data_hold", $signed(wr_data), last_data);
                if (exp_wr.size() != 0 && exp_wr[0].cyc <= cyc) begin
                    chk("wr_en_missing", wr_en, 1);
                    me = exp_wr.pop_front();
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    chk("done_unexpected", done, 0);
                end else begin
                    md = exp_done.pop_front();
                    chk("done_cycle", cyc, md);
                end
            end else if (exp_done.size() != 0 && exp_done[0] <= cyc) begin
                chk("done_missing", done, 1);
                md = exp_done.pop_front();
            end
        end
    end

    function automatic int beat(input int k);
        if (k < dv.size()) return dv[k];
        return int'($urandom) >>> $urandom_range(0, 24);
    endfunction

    task automatic wait_idle();
        int g = 0;
        while ((m_active || cyc < m_next_idle) && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) chk("idle_timeout", busy, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_acc_ready"}, acc_ready, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
    endtask

    task automatic do_job(input int base, input int len, input int sh,
                          input bit relu, input int gap, input bit hold);
        int g = 0;
        int t = 0;
        int r = 0;
        wait_idle();
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = base[AW-1:0];
        length    = len[AW:0];
        shift     = sh[4:0];
        relu_en   = relu;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        while (m_k < len && g < 4000) begin
            if (hold) begin
                r = int'($urandom);
                base_addr = r[AW-1:0];
                length    = r[AW+12:12];
            end
            case (gap)
                0:       acc_valid = 1'b1;
                1:       acc_valid = (t % 2 == 0);
                default: acc_valid = ($urandom_range(0, 3) != 0);
            endcase
            acc_in = beat(m_k);
            t++;
            g++;
            @(posedge clk);
            #1;
        end
        acc_valid = 1'b0;
        start     = 1'b0;
        if (g >= 4000) chk("job_timeout", m_k, len);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        rst_n = 1'b0;
        #2;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        dv = '{10, -3, 127, 128};
        do_job(5, 4, 0, 1'b0, 0, 1'b0);
        dv = '{24, -24, 100000, -100000};
        do_job(100, 4, 4, 1'b0, 0, 1'b0);
        dv = '{-50, 50};
        do_job(200, 2, 0, 1'b1, 0, 1'b0);
        dv.delete();
        do_job(1022, 3, 0, 1'b0, 1, 1'b0);
        do_job(7, 0, 3, 1'b0, 0, 1'b0);
        do_job(300, 5, 2, 1'b1, 2, 1'b1);

        // Abort a job after two accepted beats.
        wait_idle();
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = 10'd50;
        length = 11'd4;
        shift = 5'd0;
        relu_en = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        g = 0;
        while (m_k < 2 && g < 50) begin
            acc_valid = 1'b1;
            acc_in = beat(m_k);
            g++;
            @(posedge clk);
            #1;
        end
        chk("abort_beats", m_k, 2);
        #2;
        rst_n = 1'b0;
        acc_valid = 1'b0;
        #1;
        check_zero("abort");
        exp_wr.delete();
        exp_done.delete();
        last_addr = 0;
        last_data = 0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        do_job(60, 4, 1, 1'b0, 0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            do_job($urandom_range(0, 1023), $urandom_range(0, 24),
                   $urandom_range(0, 31), 1'($urandom_range(0, 1)),
                   2, 1'($urandom_range(0, 1)));
        end

        wait_idle();
        repeat (6) @(negedge clk);
        chk("left_writes", exp_wr.size(), 0);
        chk("left_dones", exp_done.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/res_writeback.md
RES_WRITEBACK -- requirements
Module: res_writeback

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- BIT_DEPTH, 8, width of the signed result word written to the result buffer.
- ADDR_WIDTH, 10, width of the result buffer address.
- ACC_WIDTH, 32, width of the signed accumulator input.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse that launches a job.
- base_addr, in, ADDR_WIDTH, first write address; sampled on an accepted start.
- length, in, ADDR_WIDTH+1, beats in the job; sampled on an accepted start.
- shift, in, 5, right-shift amount; sampled on an accepted start.
- relu_en, in, 1, clamp negatives to 0; sampled on an accepted start.
- acc_in, in, ACC_WIDTH, signed accumulator beat.
- acc_valid, in, 1, acc_in is valid.
- acc_ready, out, 1, block accepts acc_in this cycle.
- wr_en, out, 1, result buffer write enable.
- wr_addr, out, ADDR_WIDTH, result buffer write address.
- wr_data, out, BIT_DEPTH, result buffer write data.
- busy, out, 1, job in progress.
- done, out, 1, one-cycle job-complete pulse.

REQ-003 The block SHALL use one clock, clk, with reset rst_n asynchronous and active-low.

Function
REQ-004 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-005 IDLE->RUN on start; IDLE->DONE on start with length==0.
REQ-006 start SHALL be ignored when the state is not IDLE.
REQ-007 In RUN, acc_ready SHALL be 1 exactly while accepted_count < length; a beat is accepted when acc_valid and acc_ready are both 1.
REQ-008 RUN->DRAIN in the cycle the length-th beat is accepted; DRAIN->DONE when the pipeline is empty; DONE->IDLE after exactly 1 cycle.
REQ-009 done SHALL be 1 only in DONE; busy SHALL be 1 in RUN and DRAIN.
REQ-010 Latency: a beat accepted at edge N SHALL produce wr_en=1 in the cycle following edge N+2 (two register stages); there is no downstream backpressure.
REQ-011 Stage 1 SHALL compute arithmetic shift right by shift of (acc_in + (1<<(shift-1))), round-half-up; with shift==0 it SHALL pass the value unchanged. The add SHALL be evaluated at ACC_WIDTH+1 bits so it cannot overflow.
REQ-012 Stage 2 SHALL force negative values to 0 if relu_en, then saturate to the signed range [-2^(BIT_DEPTH-1), 2^(BIT_DEPTH-1)-1].
REQ-013 The k-th accepted beat (k from 0) SHALL be written to wr_addr = (base_addr + k) mod 2^ADDR_WIDTH; wrap-around is silent.
REQ-014 Gaps in acc_valid SHALL produce corresponding gaps in wr_en, with no reordering.
REQ-015 When wr_en is 0, wr_addr and wr_data SHALL hold their last values.

Reset
REQ-016 On rst_n=0: state IDLE; acc_ready, wr_en, busy and done are 0; wr_addr and wr_data are 0; counters are 0; pipeline valids are cleared.
REQ-017 A reset mid-job SHALL abort the job with no further writes, and SHALL NOT produce a done pulse.

Structure
REQ-018 The FSM state encoding and the default widths (BIT_DEPTH, ADDR_WIDTH, ACC_WIDTH) SHALL reside in the shared package npu_pkg.
REQ-019 Rounding, shift, ReLU and saturation SHALL be one combinational sub-module, res_quant; res_writeback SHALL hold the FSM, the counters and the pipeline registers.

Verification
REQ-020 start, base_addr=5, length=4, shift=0, relu_en=0, acc_in=10,-3,127,128 back-to-back -> writes (5,10),(6,-3),(7,127),(8,127); done 1 cycle after the last write.
REQ-021 shift=4, acc_in=24 -> 2 (24+8=32, >>4); acc_in=-24 -> -1; acc_in=100000 -> 127; acc_in=-100000 -> -128.
REQ-022 relu_en=1, acc_in=-50,50 -> wr_data 0,50.
REQ-023 base_addr=1022, length=3 -> wr_addr 1022,1023,0; acc_valid toggled 1,0,1,0,1 -> wr_en has matching gaps.
REQ-024 length=0 -> no wr_en; done at 2nd edge after start; start held high during RUN -> no restart, counts unchanged.
REQ-025 rst_n dropped after 2 of 4 beats accepted -> all outputs 0 immediately, no done; a new job afterwards runs correctly.
